// File: rtl/data_memory_port.sv
// data_memory_port
// Load/store responder for the core's data-memory initiator. It serves
// byte-lane writes and 32-bit reads against a byte-wide synchronous block RAM,
// one byte per cycle, and decodes a single memory-mapped LED register.
//
// Ports:
//   clk24              core clock, all logic on posedge
//   reset              asynchronous, active-high
//   req_valid/ready    request handshake (accept when both high at posedge)
//   req_addr           byte address
//   req_write_sections bit0 = byte0, bit1 = byte1, bit2 = bytes 2+3; 0 = read
//   req_wdata          write data, byte n = bits [8n+7:8n]
//   resp_valid         one-cycle completion pulse
//   resp_rdata         read data, held until the next read response
//   resp_error         misalignment trap flag, qualified by resp_valid
//   led_on             LED register
//
// Build options:
//   MISALIGN_TRAP_EN   when defined, misaligned RAM accesses complete
//                      immediately with resp_error instead of going bytewise
module data_memory_port #(
    parameter int unsigned MEMORY_SIZE = 32'h1000,
    parameter logic [31:0] LED_ADDR    = 32'h8000_0000
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_write_sections,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        led_on
);

    localparam int unsigned ADDR_W = $clog2(MEMORY_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MMIO   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [1:0]          idx_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [2:0]          sections_r;
    logic [31:0]         wdata_r;
    logic                trap_r;
    logic                req_ready_r;
    logic                resp_valid_r;
    logic [31:0]         resp_rdata_r;
    logic                led_on_r;

    logic                accept_s;
    logic                is_mmio_s;
    logic                trap_s;
    logic                is_read_s;
    logic                lane_en_s;
    logic                ram_we_s;
    logic [7:0]          ram_wdata_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic                cap_en_s;
    logic [1:0]          cap_lane_s;
    logic                done_s;

    logic [7:0]          mem_r [MEMORY_SIZE];
    logic [7:0]          ram_rdata_r;

    assign accept_s  = req_valid && req_ready_r;
    assign is_mmio_s = (req_addr == LED_ADDR);
    assign is_read_s = (sections_r == 3'b000);

`ifdef MISALIGN_TRAP_EN
    // Misalignment rule: word halves need a word-aligned base, the byte1-only
    // or byte0+1 pattern needs a halfword-aligned base, reads are always words.
    function automatic logic misaligned_f(input logic [31:0] a, input logic [2:0] s);
        logic m;
        m = 1'b0;
        if (s == 3'b000) begin
            m = (a[1:0] != 2'b00);
        end else begin
            if (s[2] && (a[1:0] != 2'b00)) m = 1'b1;
            if (((s == 3'b010) || (s == 3'b011)) && a[0]) m = 1'b1;
        end
        return m;
    endfunction

    logic resp_error_r;

    assign trap_s     = misaligned_f(req_addr, req_write_sections) && !is_mmio_s;
    assign resp_error = resp_error_r;

    // Error flag accompanies the DRAIN completion of a trapped request.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            resp_error_r <= 1'b0;
        end else begin
            resp_error_r <= (state_r == ST_DRAIN) && trap_r;
        end
    end
`else
    assign trap_s     = 1'b0;
    assign resp_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mmio_s) begin
                        state_next_s = ST_MMIO;
                    end else if (trap_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_ACCESS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MMIO:   state_next_s = ST_IDLE;
            ST_ACCESS: begin
                if (idx_r == 2'd3) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            ST_DRAIN:  state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Per-cycle RAM controls and capture decode.
    always_comb begin
        lane_en_s = 1'b0;
        case (idx_r)
            2'd0:    lane_en_s = sections_r[0];
            2'd1:    lane_en_s = sections_r[1];
            default: lane_en_s = sections_r[2];
        endcase
        ram_addr_s  = addr_r + {{(ADDR_W-2){1'b0}}, idx_r};
        ram_wdata_s = wdata_r[{idx_r, 3'b000} +: 8];
        ram_we_s    = (state_r == ST_ACCESS) && lane_en_s;
        // Read data lags the issued address by one cycle, so lane idx-1 lands
        // during ACCESS and lane 3 lands in DRAIN.
        cap_lane_s  = (state_r == ST_DRAIN) ? 2'd3 : (idx_r - 2'd1);
        cap_en_s    = is_read_s && !trap_r &&
                      (((state_r == ST_ACCESS) && (idx_r != 2'd0)) || (state_r == ST_DRAIN));
        done_s      = (state_r == ST_MMIO) || (state_r == ST_DRAIN);
    end

    // Byte-wide RAM with synchronous read; not touched by reset.
    always_ff @(posedge clk24) begin
        if (ram_we_s) begin
            mem_r[ram_addr_s] <= ram_wdata_s;
        end
        ram_rdata_r <= mem_r[ram_addr_s];
    end

    // Request latch, byte counter and registered outputs.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            addr_r       <= {ADDR_W{1'b0}};
            sections_r   <= 3'b000;
            wdata_r      <= 32'h0000_0000;
            trap_r       <= 1'b0;
            idx_r        <= 2'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
            led_on_r     <= 1'b0;
        end else begin
            req_ready_r  <= (state_next_s == ST_IDLE);
            resp_valid_r <= done_s;
            if (accept_s) begin
                addr_r     <= req_addr[ADDR_W-1:0];
                sections_r <= req_write_sections;
                wdata_r    <= req_wdata;
                trap_r     <= trap_s;
            end
            if (state_r == ST_ACCESS) begin
                idx_r <= idx_r + 2'd1;
            end else begin
                idx_r <= 2'd0;
            end
            if (state_r == ST_MMIO) begin
                if (sections_r != 3'b000) begin
                    led_on_r <= (wdata_r != 32'h0000_0000);
                end else begin
                    resp_rdata_r <= {31'h0000_0000, led_on_r};
                end
            end
            if (cap_en_s) begin
                resp_rdata_r[{cap_lane_s, 3'b000} +: 8] <= ram_rdata_r;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign led_on     = led_on_r;

endmodule
